// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the four requesters and the round-robin mux arbiter.
// slave = arbiter side, master = requester/harness side.
interface mux_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       busy;
  logic       s0;
  logic       s1;
  logic [1:0] owner;

  modport master (output req, input gnt, busy, s0, s1, owner);
  modport slave  (input req, output gnt, busy, s0, s1, owner);
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the 4-to-1 mux selects; all outputs registered.
// Define MUX_ARB_TIMEOUT_EN to enable MAX_HOLD forced rotation; otherwise the owner locks.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input logic             clk,
  input logic             rst,
  mux_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_n;
  logic [3:0] gnt_q, gnt_n;
  logic       busy_q, busy_n;
  logic [1:0] owner_q, owner_n;
  logic [1:0] last_q, last_n;
  logic [1:0] win;
  logic [1:0] idx;
  logic       found;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_range
    $error("mux_rr_arbiter: MAX_HOLD must be within 1..255");
  end

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_n;
  logic       contender;

  assign contender = |(bus.req & ~(4'b0001 << owner_q));
`endif

  // Scan starts just past the last winner, so last itself is checked last.
  always_comb begin
    win   = last_q + 2'd1;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && bus.req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt_q;
    owner_n = owner_q;
    last_n  = last_q;
`ifdef MUX_ARB_TIMEOUT_EN
    hold_n  = hold_q;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << win;
          owner_n = win;
          last_n  = win;
`ifdef MUX_ARB_TIMEOUT_EN
          hold_n  = '0;
`endif
        end
      end
      GRANT: begin
        if (!bus.req[owner_q]) begin
          state_n = IDLE;
          gnt_n   = '0;
        end
`ifdef MUX_ARB_TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          if (contender) begin
            state_n = IDLE;
            gnt_n   = '0;
          end else begin
            hold_n  = '0;
          end
        end else begin
          hold_n = hold_q + 8'd1;
        end
`endif
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
    busy_n = (state_n == GRANT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      owner_q <= '0;
      last_q  <= 2'd3;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_q  <= '0;
`endif
    end else begin
      state   <= state_n;
      gnt_q   <= gnt_n;
      busy_q  <= busy_n;
      owner_q <= owner_n;
      last_q  <= last_n;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_q  <= hold_n;
`endif
    end
  end

  // owner only reloads on a new grant from IDLE, so selects are stable while busy.
  assign bus.gnt   = gnt_q;
  assign bus.busy  = busy_q;
  assign bus.owner = owner_q;
  assign bus.s0    = owner_q[0];
  assign bus.s1    = owner_q[1];

endmodule
